// File: rtl/demux1to4_stream.sv
// 1-to-4 valid/ready stream demux with a one-word holding slot per channel.
// Define DEMUX1TO4_CNT_EN to add per-channel delivered-word counters on cnt.
module demux1to4_stream #(
  parameter int N  = 32,
  parameter int CW = 16
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [N-1:0]    in_data,
  input  logic [1:0]      in_sel,
  output logic [3:0]      out_valid,
  input  logic [3:0]      out_ready,
  output logic [4*N-1:0]  out_data
`ifdef DEMUX1TO4_CNT_EN
  ,
  output logic [4*CW-1:0] cnt
`endif
);

  logic [3:0]         valid_q;
  logic [3:0]         valid_d;
  logic [3:0][N-1:0]  data_q;
  logic [3:0][N-1:0]  data_d;
  logic [3:0]         fill;
  logic [3:0]         drain;
  logic               accept;

  assign in_ready = !valid_q[in_sel] || out_ready[in_sel];
  assign accept   = in_valid && in_ready;

  // A slot drained and refilled on one edge stays full: no bubble.
  always_comb begin
    fill    = '0;
    drain   = valid_q & out_ready;
    valid_d = valid_q;
    data_d  = data_q;
    if (accept) begin
      fill[in_sel] = 1'b1;
    end
    for (int k = 0; k < 4; k++) begin
      valid_d[k] = fill[k] || (valid_q[k] && !drain[k]);
      if (fill[k]) begin
        data_d[k] = in_data;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= '0;
      data_q  <= '0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
    end
  end

  assign out_valid = valid_q;
  assign out_data  = data_q;

`ifdef DEMUX1TO4_CNT_EN
  logic [3:0][CW-1:0] cnt_q;
  logic [3:0][CW-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    for (int k = 0; k < 4; k++) begin
      if (drain[k]) begin
        cnt_d[k] = cnt_q[k] + CW'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt = cnt_q;
`endif

endmodule

// File: tb/tb_demux1to4_stream.sv
// Directed bench for demux1to4_stream.
// Exercises reset, routing, backpressure, throughput and channel independence.
module tb_demux1to4_stream;

  localparam int N  = 32;
`ifdef DEMUX1TO4_CNT_EN
  localparam int CW = 4;
`else
  localparam int CW = 16;
`endif

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            in_valid = 1'b0;
  logic            in_ready;
  logic [N-1:0]    in_data = '0;
  logic [1:0]      in_sel = '0;
  logic [3:0]      out_valid;
  logic [3:0]      out_ready = '0;
  logic [4*N-1:0]  out_data;
`ifdef DEMUX1TO4_CNT_EN
  logic [4*CW-1:0] cnt;
`endif

  int checks = 0;
  int errors = 0;

  demux1to4_stream #(.N(N), .CW(CW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_sel    (in_sel),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data)
`ifdef DEMUX1TO4_CNT_EN
    ,
    .cnt       (cnt)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [127:0] got,
                     input logic [127:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [N-1:0] lane(input int k);
    return out_data[k*N +: N];
  endfunction

  initial begin
    // Reset state
    repeat (2) step();
    chk("rst_valid", 128'(out_valid), 128'h0);
    chk("rst_data", out_data, 128'h0);
    chk("rst_in_ready", 128'(in_ready), 128'h1);
    @(negedge clk);
    rst_n = 1'b1;

    // Reset mid-stream
    in_valid = 1'b1;
    in_sel = 2'd0;
    in_data = 32'hDEADBEEF;
    step();
    in_valid = 1'b0;
    chk("fill0_valid", 128'(out_valid), 128'h1);
    chk("fill0_data", 128'(lane(0)), 128'hDEADBEEF);
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_valid", 128'(out_valid), 128'h0);
    chk("async_rst_data", out_data, 128'h0);
    #1 rst_n = 1'b1;

    // Routing to all four lanes
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b1;
      in_sel = 2'(i);
      in_data = {8{4'(i + 1)}};
      #1;
      chk("route_in_ready", 128'(in_ready), 128'h1);
      step();
    end
    in_valid = 1'b0;
    chk("route_valid", 128'(out_valid), 128'hF);
    chk("route_data", out_data,
        128'h44444444_33333333_22222222_11111111);
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b1;
      in_sel = 2'(i);
      #1;
      chk("full_in_ready", 128'(in_ready), 128'h0);
    end

    // Backpressure on ch2, then drain+refill same edge
    in_sel = 2'd2;
    in_data = 32'hAA;
    #1;
    chk("bp_in_ready", 128'(in_ready), 128'h0);
    step();
    chk("bp_hold", 128'(lane(2)), 128'h33333333);
    chk("bp_valid", 128'(out_valid), 128'hF);
    out_ready = 4'b0100;
    #1;
    chk("bp_release_ready", 128'(in_ready), 128'h1);
    step();
    in_valid = 1'b0;
    out_ready = 4'b0000;
    chk("refill_valid", 128'(out_valid), 128'hF);
    chk("refill_data", 128'(lane(2)), 128'hAA);

    // Drain everything
    out_ready = 4'b1111;
    step();
    out_ready = 4'b0000;
    chk("drain_valid", 128'(out_valid), 128'h0);

    // Throughput: 8 back-to-back words on ch1
    out_ready = 4'b0010;
    for (int i = 0; i < 8; i++) begin
      in_valid = 1'b1;
      in_sel = 2'd1;
      in_data = 32'h100 + 32'(i);
      #1;
      chk("tput_in_ready", 128'(in_ready), 128'h1);
      step();
      chk("tput_valid", 128'(out_valid), 128'h2);
      chk("tput_data", 128'(lane(1)), 128'h100 + 128'(i));
    end
    in_valid = 1'b0;
    step();
    chk("tput_end_valid", 128'(out_valid), 128'h0);

    // Independence: ch0 stalled, stream into ch3
    out_ready = 4'b0000;
    in_valid = 1'b1;
    in_sel = 2'd0;
    in_data = 32'hC0C0C0C0;
    step();
    out_ready = 4'b1000;
    for (int i = 0; i < 3; i++) begin
      in_sel = 2'd3;
      in_data = 32'h300 + 32'(i);
      #1;
      chk("ind_in_ready", 128'(in_ready), 128'h1);
      step();
      chk("ind_ch0", 128'(lane(0)), 128'hC0C0C0C0);
      chk("ind_ch3", 128'(lane(3)), 128'h300 + 128'(i));
      chk("ind_valid", 128'(out_valid), 128'h9);
    end
    in_sel = 2'd0;
    #1;
    chk("ind_ch0_stall", 128'(in_ready), 128'h0);

    // in_valid=0 writes nothing
    in_valid = 1'b0;
    out_ready = 4'b0000;
    in_sel = 2'd2;
    in_data = 32'hFFFFFFFF;
    step();
    chk("idle_valid", 128'(out_valid), 128'h9);
    chk("idle_ch2", 128'(lane(2)), 128'hAA);

`ifdef DEMUX1TO4_CNT_EN
    // 17 handshakes on ch1 wrap a 4-bit counter to 1
    #2 rst_n = 1'b0;
    #1;
    chk("cnt_rst", 128'(cnt), 128'h0);
    #1 rst_n = 1'b1;
    out_ready = 4'b0010;
    for (int i = 0; i < 17; i++) begin
      in_valid = 1'b1;
      in_sel = 2'd1;
      in_data = 32'(i);
      step();
    end
    in_valid = 1'b0;
    step();
    chk("cnt_wrap", 128'(cnt), 128'h0010);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
